// File: rtl/ads8528_parallel_reader.sv
// rtl/ads8528_parallel_reader.sv - ADS8528 parallel-bus conversion trigger and per-frame word reader
module ads8528_parallel_reader #(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_CHANNELS   = 8,
  parameter int CONVST_CYCLES  = 4,
  parameter int RD_LOW_CYCLES  = 3,
  parameter int RD_HIGH_CYCLES = 2,
  parameter int BUSY_TIMEOUT   = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  busy,
  input  logic [DATA_WIDTH-1:0] databits_in,
  output logic                  read_n,
  output logic                  chipselect_n,
  output logic                  write_n,
  output logic                  hardware_mode_n,
  output logic                  parallel_mode_n,
  output logic                  standby_n,
  output logic                  range_xclock,
  output logic [3:0]            conv_start,
  output logic [DATA_WIDTH-1:0] sample_data,
  output logic [2:0]            sample_channel,
  output logic                  sample_valid,
  output logic                  frame_done,
  output logic                  timeout_err,
  output logic                  overrun,
  output logic                  idle
);

  // One CONVST line serves a pair of channels.
  localparam int         NUM_CONV  = (NUM_CHANNELS + 1) / 2;
  localparam logic [3:0] CONV_MASK = 4'((1 << NUM_CONV) - 1);
  localparam int         MAX_A     = (CONVST_CYCLES > RD_LOW_CYCLES) ? CONVST_CYCLES : RD_LOW_CYCLES;
  localparam int         MAX_B     = (RD_HIGH_CYCLES > BUSY_TIMEOUT) ? RD_HIGH_CYCLES : BUSY_TIMEOUT;
  localparam int         MAX_CNT   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int         CW        = $clog2(MAX_CNT + 1);
  localparam logic [2:0] LAST_WORD = 3'(NUM_CHANNELS - 1);

  typedef enum logic [2:0] {
    IDLE,
    CONVST,
    WAIT_BUSY_HI,
    WAIT_BUSY_LO,
    RD_LOW,
    RD_HIGH
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    word, word_nx;
  logic          busy_meta, busy_sync;
  logic          capture;

  assign hardware_mode_n = 1'b0;
  assign parallel_mode_n = 1'b0;
  assign standby_n       = 1'b1;
  assign write_n         = 1'b1;
  assign range_xclock    = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      word           <= '0;
      busy_meta      <= 1'b0;
      busy_sync      <= 1'b0;
      sample_data    <= '0;
      sample_channel <= '0;
      sample_valid   <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      word         <= word_nx;
      busy_meta    <= busy;
      busy_sync    <= busy_meta;
      sample_valid <= capture;
      if (capture) begin
        sample_data    <= databits_in;
        sample_channel <= word;
      end
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt + CW'(1);
    word_nx      = word;
    capture      = 1'b0;
    frame_done   = 1'b0;
    timeout_err  = 1'b0;
    read_n       = 1'b1;
    chipselect_n = 1'b0;
    conv_start   = 4'b0000;
    idle         = 1'b0;

    case (state)
      IDLE: begin
        chipselect_n = 1'b1;
        idle         = 1'b1;
        cnt_nx       = '0;
        if (start) begin
          state_nx = CONVST;
          word_nx  = '0;
        end
      end
      CONVST: begin
        conv_start = CONV_MASK;
        if (cnt == CW'(CONVST_CYCLES - 1)) begin
          state_nx = WAIT_BUSY_HI;
          cnt_nx   = '0;
        end
      end
      // The busy level is checked before the timeout so a late edge still wins.
      WAIT_BUSY_HI: begin
        if (busy_sync) begin
          state_nx = WAIT_BUSY_LO;
          cnt_nx   = '0;
        end else if (cnt == CW'(BUSY_TIMEOUT)) begin
          timeout_err = 1'b1;
          state_nx    = IDLE;
          cnt_nx      = '0;
        end
      end
      WAIT_BUSY_LO: begin
        if (!busy_sync) begin
          state_nx = RD_LOW;
          cnt_nx   = '0;
        end else if (cnt == CW'(BUSY_TIMEOUT)) begin
          timeout_err = 1'b1;
          state_nx    = IDLE;
          cnt_nx      = '0;
        end
      end
      RD_LOW: begin
        read_n = 1'b0;
        if (cnt == CW'(RD_LOW_CYCLES - 1)) begin
          capture  = 1'b1;
          state_nx = RD_HIGH;
          cnt_nx   = '0;
        end
      end
      RD_HIGH: begin
        if (cnt == CW'(RD_HIGH_CYCLES - 1)) begin
          cnt_nx = '0;
          if (word == LAST_WORD) begin
            frame_done = 1'b1;
            state_nx   = IDLE;
          end else begin
            word_nx  = word + 3'd1;
            state_nx = RD_LOW;
          end
        end
      end
      default: begin
        chipselect_n = 1'b1;
        state_nx     = IDLE;
        cnt_nx       = '0;
      end
    endcase

    overrun = start && (state != IDLE);
  end

endmodule
